// File: rtl/sevenseg_reader_if.sv
// Decoded-digit stream between the seven-segment reader and its consumer.
// The producer holds digit_out/digit_valid; the consumer answers with digit_ready.
interface sevenseg_reader_if;
  logic [3:0] digit_out;
  logic       digit_valid;
  logic       digit_ready;

  modport master (output digit_out, output digit_valid, input  digit_ready);
  modport slave  (input  digit_out, input  digit_valid, output digit_ready);
endinterface

// File: rtl/sevenseg_reader.sv
// Seven-segment bus monitor: debounces the segment pattern, decodes it to BCD,
// checks the 0..9 up-count sequence and streams digits through a one-entry buffer.
module sevenseg_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       segments,
  input  logic             clear_err,
  sevenseg_reader_if.master dout,
  output logic             blank,
  output logic             seq_error,
  output logic             bad_pattern,
  output logic             overflow,
  output logic [CNT_W-1:0] err_count
);

  localparam int SC_W = $clog2(STABLE_CYCLES + 1);

  typedef enum logic {IDLE, FILTER} state_t;
  typedef enum logic [1:0] {PAT_DIGIT, PAT_BLANK, PAT_INVALID} pat_kind_t;
  typedef struct packed {
    pat_kind_t  kind;
    logic [3:0] digit;
  } pat_t;

  function automatic pat_t decode(input logic [6:0] s);
    pat_t p;
    p.kind  = PAT_DIGIT;
    p.digit = 4'd0;
    case (s)
      7'h7E:   p.digit = 4'd0;
      7'h30:   p.digit = 4'd1;
      7'h6D:   p.digit = 4'd2;
      7'h79:   p.digit = 4'd3;
      7'h33:   p.digit = 4'd4;
      7'h5B:   p.digit = 4'd5;
      7'h5F:   p.digit = 4'd6;
      7'h70:   p.digit = 4'd7;
      7'h7F:   p.digit = 4'd8;
      7'h7B:   p.digit = 4'd9;
      7'h00:   p.kind  = PAT_BLANK;
      default: p.kind  = PAT_INVALID;
    endcase
    return p;
  endfunction

  state_t           state, state_nxt;
  logic [6:0]       cand, accepted;
  logic [SC_W-1:0]  stab_cnt, cnt_nxt;
  logic             cand_load, commit;
  logic             have_prev;
  logic [3:0]       prev, prev_inc;
  logic [3:0]       dout_q;
  logic             valid_q;
  pat_t             pat;
  logic             emit, seq_err_nxt, bad_nxt, xfer, load, inc;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned; a missing default would infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = stab_cnt;
    cand_load = 1'b0;
    commit    = 1'b0;
    if (segments != cand) begin
      // Any change restarts the filter; this edge is the first sample.
      cand_load = 1'b1;
      cnt_nxt   = SC_W'(1);
      state_nxt = FILTER;
    end else if (state == FILTER) begin
      if (stab_cnt == SC_W'(STABLE_CYCLES - 1)) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        commit    = (cand != accepted);
      end else begin
        cnt_nxt = stab_cnt + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cand     <= 7'h00;
      stab_cnt <= '0;
    end else begin
      state    <= state_nxt;
      stab_cnt <= cnt_nxt;
      if (cand_load) cand <= segments;
    end
  end

  always_comb begin
    pat         = decode(cand);
    prev_inc    = (prev == 4'd9) ? 4'd0 : prev + 4'd1;
    emit        = commit && (pat.kind == PAT_DIGIT);
    seq_err_nxt = emit && have_prev && (pat.digit != prev_inc);
    bad_nxt     = commit && (pat.kind == PAT_INVALID);
    xfer        = valid_q && dout.digit_ready;
    load        = emit && (!valid_q || xfer);
    inc         = seq_err_nxt || bad_nxt;
  end

  // Commit side: accepted pattern, sequence history and status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      accepted    <= 7'h00;
      have_prev   <= 1'b0;
      prev        <= 4'd0;
      blank       <= 1'b1;
      seq_error   <= 1'b0;
      bad_pattern <= 1'b0;
    end else begin
      seq_error   <= seq_err_nxt;
      bad_pattern <= bad_nxt;
      if (commit) begin
        accepted <= cand;
        case (pat.kind)
          PAT_DIGIT: begin
            blank     <= 1'b0;
            prev      <= pat.digit;
            have_prev <= 1'b1;
          end
          PAT_BLANK: begin
            blank     <= 1'b1;
            have_prev <= 1'b0;
          end
          default:   have_prev <= 1'b0;
        endcase
      end
    end
  end

  // One-entry output buffer; a dropped digit still advanced the sequence check.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q   <= 4'd0;
      valid_q  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= emit && !load;
      if (load) begin
        dout_q  <= pat.digit;
        valid_q <= 1'b1;
      end else if (xfer) begin
        valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
    end else if (clear_err) begin
      err_count <= '0;
    end else if (inc && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + 1'b1;
    end
  end

  assign dout.digit_out   = dout_q;
  assign dout.digit_valid = valid_q;

endmodule

// File: tb/tb_sevenseg_reader.sv
// Directed bench for sevenseg_reader: filter latency, glitch rejection, sequence
// checking, buffer overflow, error counting and asynchronous reset.
module tb_sevenseg_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] segments;
  logic       clear_err;
  logic       blank, seq_error, bad_pattern, overflow;
  logic [7:0] err_count;

  sevenseg_reader_if dif ();

  sevenseg_reader #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .segments    (segments),
    .clear_err   (clear_err),
    .dout        (dif),
    .blank       (blank),
    .seq_error   (seq_error),
    .bad_pattern (bad_pattern),
    .overflow    (overflow),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_seq, n_bad, n_ovf;
  logic [3:0] got[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    n_seq = 0;
    n_bad = 0;
    n_ovf = 0;
    got.delete();
  endtask

  // Holds a pattern for n edges, tallying pulse cycles and delivered digits.
  task automatic hold(input logic [6:0] seg, input int n);
    segments = seg;
    for (int i = 0; i < n; i++) begin
      tick();
      if (seq_error)   n_seq++;
      if (bad_pattern) n_bad++;
      if (overflow)    n_ovf++;
      if (dif.digit_valid && dif.digit_ready) got.push_back(dif.digit_out);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; segments = 7'h00; clear_err = 1'b0; dif.digit_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    n_checks++; if (blank !== 1'b1) begin n_fail++; $display("FAIL reset_blank: got %b expected 1", blank); end
    n_checks++; if (dif.digit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", dif.digit_valid); end
    n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err: got %0d expected 0", err_count); end
    n_checks++; if (dif.digit_out !== 4'd0) begin n_fail++; $display("FAIL reset_digit: got %0d expected 0", dif.digit_out); end
    clear_obs();
    hold(7'h00, 20);
    n_checks++; if ((n_seq + n_bad + n_ovf) != 0) begin n_fail++; $display("FAIL reset_quiet_pulses: got %0d expected 0", n_seq + n_bad + n_ovf); end
    n_checks++; if (got.size() != 0) begin n_fail++; $display("FAIL reset_quiet_digits: got %0d expected 0", got.size()); end
  endtask

  task automatic test_latency();
    segments = 7'h7E;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++; if (dif.digit_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early_edge%0d: got %b expected 0", i, dif.digit_valid); end
    end
    tick();
    n_checks++; if (dif.digit_valid !== 1'b1) begin n_fail++; $display("FAIL latency_valid: got %b expected 1", dif.digit_valid); end
    n_checks++; if (dif.digit_out !== 4'd0) begin n_fail++; $display("FAIL latency_digit: got %0d expected 0", dif.digit_out); end
    tick();
    n_checks++; if (dif.digit_valid !== 1'b0) begin n_fail++; $display("FAIL latency_one_cycle: got %b expected 0", dif.digit_valid); end
    clear_obs();
    hold(7'h30, 6);
    n_checks++; if (got.size() != 1 || got[0] !== 4'd1) begin n_fail++; $display("FAIL latency_second_digit: got %0d items expected one digit 1", got.size()); end
    n_checks++; if (n_seq != 0) begin n_fail++; $display("FAIL latency_seq: got %0d expected 0", n_seq); end
  endtask

  task automatic test_glitch();
    clear_obs();
    hold(7'h30, 2);
    hold(7'h5F, 1);
    hold(7'h6D, 6);
    n_checks++; if (got.size() != 1) begin n_fail++; $display("FAIL glitch_count: got %0d expected 1", got.size()); end
    n_checks++; if (got.size() > 0 && got[0] !== 4'd2) begin n_fail++; $display("FAIL glitch_digit: got %0d expected 2", got[0]); end
    n_checks++; if (n_seq != 0) begin n_fail++; $display("FAIL glitch_seq: got %0d expected 0", n_seq); end
  endtask

  task automatic test_sequence();
    clear_obs();
    hold(7'h79, 6);
    hold(7'h5B, 6);
    n_checks++; if (n_seq != 1) begin n_fail++; $display("FAIL seq_3to5_pulse: got %0d expected 1", n_seq); end
    n_checks++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL seq_3to5_err: got %0d expected 1", err_count); end
    hold(7'h7B, 6);
    hold(7'h7E, 6);
    n_checks++; if (n_seq != 2) begin n_fail++; $display("FAIL seq_wrap_pulses: got %0d expected 2", n_seq); end
    n_checks++; if (err_count !== 8'd2) begin n_fail++; $display("FAIL seq_wrap_err: got %0d expected 2", err_count); end
    hold(7'h00, 6);
    n_checks++; if (blank !== 1'b1) begin n_fail++; $display("FAIL seq_blank: got %b expected 1", blank); end
    hold(7'h30, 6);
    n_checks++; if (n_seq != 2) begin n_fail++; $display("FAIL seq_after_blank: got %0d expected 2", n_seq); end
    n_checks++; if (blank !== 1'b0) begin n_fail++; $display("FAIL seq_unblank: got %b expected 0", blank); end
    n_checks++; if (got.size() != 5 || got[4] !== 4'd1) begin n_fail++; $display("FAIL seq_delivered: got %0d items expected 5 ending in 1", got.size()); end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    dif.digit_ready = 1'b0;
    hold(7'h6D, 6);
    n_checks++; if (dif.digit_valid !== 1'b1 || dif.digit_out !== 4'd2) begin n_fail++; $display("FAIL ovf_first: got valid=%b digit=%0d expected valid=1 digit=2", dif.digit_valid, dif.digit_out); end
    hold(7'h79, 6);
    n_checks++; if (n_ovf != 1) begin n_fail++; $display("FAIL ovf_pulse: got %0d expected 1", n_ovf); end
    n_checks++; if (dif.digit_out !== 4'd2) begin n_fail++; $display("FAIL ovf_hold: got %0d expected 2", dif.digit_out); end
    n_checks++; if (n_seq != 0) begin n_fail++; $display("FAIL ovf_seq: got %0d expected 0", n_seq); end
    dif.digit_ready = 1'b1;
    tick();
    n_checks++; if (dif.digit_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drain: got %b expected 0", dif.digit_valid); end
  endtask

  task automatic test_errors_and_reset();
    clear_obs();
    hold(7'h01, 6);
    n_checks++; if (n_bad != 1) begin n_fail++; $display("FAIL bad_pulse: got %0d expected 1", n_bad); end
    n_checks++; if (err_count !== 8'd3) begin n_fail++; $display("FAIL bad_err: got %0d expected 3", err_count); end
    n_checks++; if (blank !== 1'b0) begin n_fail++; $display("FAIL bad_blank_hold: got %b expected 0", blank); end
    // Clear lands on the same edge as the bad-pattern commit.
    segments = 7'h02;
    repeat (3) tick();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    n_checks++; if (bad_pattern !== 1'b1) begin n_fail++; $display("FAIL clear_coincident_pulse: got %b expected 1", bad_pattern); end
    n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL clear_wins: got %0d expected 0", err_count); end
    hold(7'h01, 6);
    dif.digit_ready = 1'b0;
    hold(7'h33, 6);
    n_checks++; if (dif.digit_valid !== 1'b1 || dif.digit_out !== 4'd4 || err_count !== 8'd1) begin n_fail++; $display("FAIL prereset_state: got valid=%b digit=%0d err=%0d expected 1/4/1", dif.digit_valid, dif.digit_out, err_count); end
    segments = 7'h5B;
    repeat (2) tick();
    #2 reset = 1'b0;
    #1;
    n_checks++; if (dif.digit_valid !== 1'b0 || dif.digit_out !== 4'd0) begin n_fail++; $display("FAIL async_reset_buf: got valid=%b digit=%0d expected 0/0", dif.digit_valid, dif.digit_out); end
    n_checks++; if (blank !== 1'b1 || err_count !== 8'd0) begin n_fail++; $display("FAIL async_reset_status: got blank=%b err=%0d expected 1/0", blank, err_count); end
    n_checks++; if ({seq_error, bad_pattern, overflow} !== 3'b000) begin n_fail++; $display("FAIL async_reset_pulses: got %b expected 000", {seq_error, bad_pattern, overflow}); end
    #2 reset = 1'b1;
    dif.digit_ready = 1'b1;
    clear_obs();
    hold(7'h5B, 6);
    n_checks++; if (got.size() != 1 || got[0] !== 4'd5) begin n_fail++; $display("FAIL post_reset_digit: got %0d items expected one digit 5", got.size()); end
    n_checks++; if (n_seq != 0) begin n_fail++; $display("FAIL post_reset_seq: got %0d expected 0", n_seq); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_sequence();
    test_back_to_back();
    test_errors_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
